rvv_vd_collector: RTL and testbench

//  Receiving end of the multi-lane vector ALU result path: gathers per-lane result chunks (vd/regi/res

---
 rtl/rvv_pkg.sv | 33 +++
 rtl/rvv_vd_lane_merge.sv | 40 ++++
 rtl/rvv_vd_collector.sv | 140 ++++++++++++++
 tb/tb_rvv_vd_collector.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared vector-unit definitions: op/SEW codes, collector state encoding, chunk-width helper.
package rvv_pkg;

  typedef enum logic [1:0] {
    OP_VV = 2'd0,
    OP_VX = 2'd1,
    OP_VI = 2'd2
  } op_type_e;

  typedef enum logic [2:0] {
    SEW_8  = 3'd0,
    SEW_16 = 3'd1,
    SEW_32 = 3'd2,
    SEW_64 = 3'd3
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WB      = 2'd2
  } collector_state_e;

  // Bits a lane delivers per cycle: the element width, capped by the lane datapath.
  function automatic int unsigned chunk_width(input logic [2:0] vsew,
                                              input int unsigned lane_width);
    int unsigned full;
    int unsigned lim;
    full = 32'd8 << vsew;
    lim  = 32'd1 << lane_width;
    return (full < lim) ? full : lim;
  endfunction

endpackage

// File: rtl/rvv_vd_lane_merge.sv
// Per-lane write mask/data generator: width mask, range check and (optional) v0 mask check.
module rvv_vd_lane_merge
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3
) (
  input  logic [2:0]      vsew,
  input  logic [63:0]     lane_vd,
  input  logic [9:0]      lane_idx,
  input  logic            lane_res,
  input  logic            vm,
  input  logic [VLEN-1:0] v0,
  output logic [VLEN-1:0] wr_mask,
  output logic [VLEN-1:0] wr_data,
  output logic            range_err
);

  int unsigned     w;
  logic [63:0]     wmask;
  logic            in_range;
  logic            active;
  logic [9:0]      elem;
  logic [VLEN-1:0] v0_sh;

  always_comb begin
    w = chunk_width(vsew, LANE_WIDTH);
    if (w > 32'd64) w = 32'd64;
    wmask    = (w == 32'd64) ? '1 : ((64'd1 << w) - 64'd1);
    in_range = (32'(lane_idx) + w) <= 32'(VLEN);
    // Shifting v0 instead of indexing keeps out-of-range element numbers harmless (reads 0).
    elem     = lane_idx >> ({1'b0, vsew} + 4'd3);
    v0_sh    = v0 >> elem;
    active   = vm | v0_sh[0];
    wr_data  = VLEN'(lane_vd & wmask) << lane_idx;
    wr_mask  = (lane_res && active && in_range) ? (VLEN'(wmask) << lane_idx) : '0;
    range_err = lane_res & active & ~in_range;
  end

endmodule

// File: rtl/rvv_vd_collector.sv
// Gathers per-lane result chunks into one VLEN-bit vd image and writes it back over valid/ready.
// Optional feature macro RVV_VD_MASK_EN adds vm/v0 ports for mask-undisturbed chunk suppression.
module rvv_vd_collector
  import rvv_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [2:0]                 vsew,
  input  logic [4:0]                 vd_addr,
  input  logic [VLEN-1:0]            vd_old,
  input  logic [(64<<NB_LANES)-1:0]  lane_vd,
  input  logic [(10<<NB_LANES)-1:0]  lane_idx,
  input  logic [(1<<NB_LANES)-1:0]   lane_res,
  input  logic                       done_in,
  output logic                       busy,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [4:0]                 wb_addr,
  output logic [VLEN-1:0]            wb_data,
  output logic                       err
`ifdef RVV_VD_MASK_EN
  ,
  input  logic                       vm,
  input  logic [VLEN-1:0]            v0
`endif
);

  localparam int NL = 1 << NB_LANES;

  collector_state_e state_q, state_d;
  logic [VLEN-1:0]  vbuf_q, vbuf_d;
  logic [2:0]       vsew_q, vsew_d;
  logic [4:0]       addr_q, addr_d;
  logic             err_q, err_d;
  logic             vm_eff;
  logic [VLEN-1:0]  v0_eff;

`ifdef RVV_VD_MASK_EN
  logic             vm_q, vm_d;
  logic [VLEN-1:0]  v0_q, v0_d;
  assign vm_eff = vm_q;
  assign v0_eff = v0_q;
`else
  assign vm_eff = 1'b1;
  assign v0_eff = '0;
`endif

  logic [VLEN-1:0] lane_mask  [NL];
  logic [VLEN-1:0] lane_wdata [NL];
  logic [NL-1:0]   lane_err;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    rvv_vd_lane_merge #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH)) u_merge (
      .vsew      (vsew_q),
      .lane_vd   (lane_vd[64*i +: 64]),
      .lane_idx  (lane_idx[10*i +: 10]),
      .lane_res  (lane_res[i]),
      .vm        (vm_eff),
      .v0        (v0_eff),
      .wr_mask   (lane_mask[i]),
      .wr_data   (lane_wdata[i]),
      .range_err (lane_err[i])
    );
  end

  always_comb begin
    state_d = state_q;
    vbuf_d  = vbuf_q;
    vsew_d  = vsew_q;
    addr_d  = addr_q;
    err_d   = err_q;
`ifdef RVV_VD_MASK_EN
    vm_d    = vm_q;
    v0_d    = v0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vbuf_d  = vd_old;
          vsew_d  = vsew;
          addr_d  = vd_addr;
          err_d   = 1'b0;
`ifdef RVV_VD_MASK_EN
          vm_d    = vm;
          v0_d    = v0;
`endif
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        // Applied in lane order so the highest lane wins on overlapping bits.
        for (int i = 0; i < NL; i++) begin
          vbuf_d = (vbuf_d & ~lane_mask[i]) | (lane_wdata[i] & lane_mask[i]);
        end
        if (|lane_err) err_d = 1'b1;
        if (done_in) state_d = ST_WB;
      end
      ST_WB: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vbuf_q  <= '0;
      vsew_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
`ifdef RVV_VD_MASK_EN
      vm_q    <= 1'b1;
      v0_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      vbuf_q  <= vbuf_d;
      vsew_q  <= vsew_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
`ifdef RVV_VD_MASK_EN
      vm_q    <= vm_d;
      v0_q    <= v0_d;
`endif
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign wb_valid = (state_q == ST_WB);
  assign wb_addr  = addr_q;
  assign wb_data  = vbuf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Directed self-checking bench for rvv_vd_collector (VLEN=128, LANE_WIDTH=3, NB_LANES=1).
module tb_rvv_vd_collector;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   vsew;
  logic [4:0]   vd_addr;
  logic [127:0] vd_old;
  logic [127:0] lane_vd;
  logic [19:0]  lane_idx;
  logic [1:0]   lane_res;
  logic         done_in;
  logic         busy;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_addr;
  logic [127:0] wb_data;
  logic         err;
`ifdef RVV_VD_MASK_EN
  logic         vm;
  logic [127:0] v0;
`endif

  int errors = 0;
  int checks = 0;
  logic [127:0] exp_data;

  rvv_vd_collector #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .vsew     (vsew),
    .vd_addr  (vd_addr),
    .vd_old   (vd_old),
    .lane_vd  (lane_vd),
    .lane_idx (lane_idx),
    .lane_res (lane_res),
    .done_in  (done_in),
    .busy     (busy),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .err      (err)
`ifdef RVV_VD_MASK_EN
    ,
    .vm       (vm),
    .v0       (v0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [63:0] d, input logic [9:0] idx);
    lane_vd[64*i +: 64]  = d;
    lane_idx[10*i +: 10] = idx;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vsew = '0; vd_addr = '0; vd_old = '0;
    lane_vd = '0; lane_idx = '0; lane_res = '0; done_in = 1'b0; wb_ready = 1'b0;
`ifdef RVV_VD_MASK_EN
    vm = 1'b1; v0 = '0;
`endif
    tick;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_wb_valid", 128'(wb_valid), 128'd0);
    check("rst_wb_data", wb_data, 128'd0);
    check("rst_wb_addr", 128'(wb_addr), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    reset = 1'b0;
    tick;

    // Eight chunk cycles of bytes 0..15, done on the last.
    vd_addr = 5'd5; vsew = 3'd0; vd_old = '0; start = 1'b1;
    tick;
    start = 1'b0;
    check("t1_busy_after_start", 128'(busy), 128'd1);
    check("t1_no_valid_after_start", 128'(wb_valid), 128'd0);
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 64'(2*k), 10'(16*k));
      set_lane(1, 64'(2*k+1), 10'(16*k+8));
      lane_res = 2'b11;
      done_in = (k == 7);
      tick;
      if (k == 6) check("t1_valid_before_done", 128'(wb_valid), 128'd0);
    end
    lane_res = '0; done_in = 1'b0;
    check("t1_wb_valid", 128'(wb_valid), 128'd1);
    check("t1_wb_data", wb_data, 128'h0F0E0D0C0B0A09080706050403020100);
    check("t1_wb_addr", 128'(wb_addr), 128'd5);
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    check("t1_valid_after_hs", 128'(wb_valid), 128'd0);
    check("t1_busy_after_hs", 128'(busy), 128'd0);

    // Strobes in IDLE must not touch the buffer.
    set_lane(0, 64'h77, 10'd0); set_lane(1, 64'h66, 10'd8); lane_res = 2'b11;
    tick;
    lane_res = '0;
    check("idle_strobe_ignored", wb_data, 128'h0F0E0D0C0B0A09080706050403020100);

    // vsew=2: width mask, overlap priority, vd_old preserved elsewhere.
    vd_old = 128'h0123456789ABCDEF_FEDCBA9876543210;
    vsew = 3'd2; vd_addr = 5'd9; start = 1'b1;
    tick;
    start = 1'b0;
    set_lane(0, 64'h11, 10'd40); set_lane(1, 64'h22, 10'd40); lane_res = 2'b11;
    tick;
    set_lane(0, 64'hFFFF_FFFF_FFFF_FFAA, 10'd0); set_lane(1, 64'hCAFE_0000_0000_00BB, 10'd8);
    lane_res = 2'b11; done_in = 1'b1;
    tick;
    lane_res = '0; done_in = 1'b0;
    exp_data = vd_old;
    exp_data[15:0]  = 16'hBBAA;
    exp_data[47:40] = 8'h22;
    check("t2_wb_data", wb_data, exp_data);
    check("t2_wb_addr", 128'(wb_addr), 128'd9);
    check("t2_err", 128'(err), 128'd0);
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;

    // Range: idx 120 is the last legal byte, idx 124 overflows.
    vd_old = {16{8'h3C}}; vsew = 3'd0; vd_addr = 5'd3; start = 1'b1;
    tick;
    start = 1'b0;
    set_lane(1, 64'h99, 10'd120); lane_res = 2'b10;
    tick;
    check("t3_edge_no_err", 128'(err), 128'd0);
    set_lane(0, 64'h5A, 10'd0); set_lane(1, 64'h77, 10'd124); lane_res = 2'b11; done_in = 1'b1;
    tick;
    lane_res = '0; done_in = 1'b0;
    exp_data = vd_old;
    exp_data[127:120] = 8'h99;
    exp_data[7:0]     = 8'h5A;
    check("t3_err_set", 128'(err), 128'd1);
    check("t3_wb_data", wb_data, exp_data);

    // Backpressure: valid/data hold, start ignored while in WB.
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      check("t4_valid_held", 128'(wb_valid), 128'd1);
      check("t4_data_stable", wb_data, exp_data);
    end
    start = 1'b0; wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    check("t4_valid_drop", 128'(wb_valid), 128'd0);
    check("t4_busy_drop", 128'(busy), 128'd0);
    check("t4_err_sticky", 128'(err), 128'd1);
    vd_old = '0; vd_addr = 5'd7; start = 1'b1;
    tick;
    start = 1'b0;
    check("t4_err_cleared", 128'(err), 128'd0);

    // Async reset mid-collect.
    set_lane(0, 64'h11, 10'd0); lane_res = 2'b01;
    tick;
    lane_res = '0;
    #3 reset = 1'b1;
    #1;
    check("t5_rst_busy", 128'(busy), 128'd0);
    check("t5_rst_valid", 128'(wb_valid), 128'd0);
    check("t5_rst_data", wb_data, 128'd0);
    check("t5_rst_addr", 128'(wb_addr), 128'd0);
    tick;
    reset = 1'b0;
    tick;
    tick;
    check("t5_no_wb_after_rst", 128'(wb_valid), 128'd0);

    // Fresh op; start and done_in together in IDLE -> start wins.
    vd_old = {16{8'hA5}}; vd_addr = 5'd12; start = 1'b1; done_in = 1'b1;
    tick;
    start = 1'b0; done_in = 1'b0;
    check("t6_start_wins_busy", 128'(busy), 128'd1);
    check("t6_start_wins_valid", 128'(wb_valid), 128'd0);
    set_lane(0, 64'h42, 10'd0); set_lane(1, 64'h24, 10'd64); lane_res = 2'b11; done_in = 1'b1;
    tick;
    lane_res = '0; done_in = 1'b0;
    exp_data = vd_old;
    exp_data[7:0]   = 8'h42;
    exp_data[71:64] = 8'h24;
    check("t6_wb_valid", 128'(wb_valid), 128'd1);
    check("t6_wb_data", wb_data, exp_data);
    check("t6_wb_addr", 128'(wb_addr), 128'd12);
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
    check("t6_busy_done", 128'(busy), 128'd0);

`ifdef RVV_VD_MASK_EN
    // Masked: even bytes take lane data, odd bytes keep vd_old.
    vd_old = '1; vsew = 3'd0; vd_addr = 5'd1; vm = 1'b0;
    v0 = 128'h5555_5555_5555_5555_5555_5555_5555_5555; start = 1'b1;
    tick;
    start = 1'b0; vm = 1'b1; v0 = '0;
    for (int k = 0; k < 8; k++) begin
      set_lane(0, 64'(2*k), 10'(16*k));
      set_lane(1, 64'(2*k+1), 10'(16*k+8));
      lane_res = 2'b11;
      done_in = (k == 7);
      tick;
    end
    lane_res = '0; done_in = 1'b0;
    exp_data = '1;
    for (int n = 0; n < 16; n += 2) exp_data[8*n +: 8] = 8'(n);
    check("mask_wb_data", wb_data, exp_data);
    check("mask_no_err", 128'(err), 128'd0);
    wb_ready = 1'b1;
    tick;
    wb_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
